// File: rtl/uart_baud_gen_frac.sv
// Fractional-N UART baud generator: oversample tick at Fclk/(Divisor + Frac/2^FRAC_W),
// with bit and mid-bit ticks derived from an oversample phase counter.
module uart_baud_gen_frac #(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FRAC_W     = 4,
  parameter int unsigned OVS        = 16,
  parameter int unsigned RESET_DIV  = 27,
  parameter int unsigned RESET_FRAC = 0
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    En,
  input  logic                    Load,
  input  logic [DIV_W-1:0]        Divisor,
  input  logic [FRAC_W-1:0]       Frac,
  input  logic                    RxSync,
  output logic                    OvsTick,
  output logic                    BitTick,
  output logic                    MidTick,
  output logic [$clog2(OVS)-1:0]  Phase
);

  localparam int unsigned PH_W = $clog2(OVS);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(OVS - 1);
  localparam logic [PH_W-1:0]  PH_MID  = PH_W'(OVS / 2 - 1);
  localparam logic [DIV_W:0]   CNT_ONE = (DIV_W + 1)'(1);

  typedef enum logic [2:0] {
    ACT_LOAD,
    ACT_SYNC,
    ACT_HOLD,
    ACT_COUNT,
    ACT_TICK
  } act_e;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic [FRAC_W-1:0] acc, acc_d;
  logic              carry_q, carry_d;
  logic [DIV_W:0]    cnt, cnt_d;
  logic [PH_W-1:0]   phase_d;
  logic              ovs_d, bit_d, mid_d;

  logic [DIV_W-1:0]  div_eff;
  logic [DIV_W:0]    period;
  logic [FRAC_W:0]   frac_sum;
  act_e              act;

  // Period is one bit wider than the divisor so all-ones plus carry cannot wrap.
  assign div_eff  = (div_q == '0) ? DIV_W'(1) : div_q;
  assign period   = {1'b0, div_eff} + {{DIV_W{1'b0}}, carry_q};
  assign frac_sum = {1'b0, acc} + {1'b0, frac_q};

  always_comb begin
    act = ACT_HOLD;
    if (Load)               act = ACT_LOAD;
    else if (RxSync)        act = ACT_SYNC;
    else if (!En)           act = ACT_HOLD;
    else if (cnt == period) act = ACT_TICK;
    else                    act = ACT_COUNT;
  end

  always_comb begin
    div_d   = div_q;
    frac_d  = frac_q;
    acc_d   = acc;
    carry_d = carry_q;
    cnt_d   = cnt;
    phase_d = Phase;
    ovs_d   = 1'b0;
    bit_d   = 1'b0;
    mid_d   = 1'b0;
    unique case (act)
      ACT_LOAD: begin
        div_d   = Divisor;
        frac_d  = Frac;
        acc_d   = '0;
        carry_d = 1'b0;
        cnt_d   = CNT_ONE;
        phase_d = '0;
      end
      ACT_SYNC: begin
        cnt_d   = CNT_ONE;
        phase_d = '0;
      end
      ACT_COUNT: begin
        cnt_d = cnt + CNT_ONE;
      end
      ACT_TICK: begin
        // Carry lengthens the period starting now, not the one just finished.
        cnt_d   = CNT_ONE;
        acc_d   = frac_sum[FRAC_W-1:0];
        carry_d = frac_sum[FRAC_W];
        phase_d = (Phase == PH_LAST) ? '0 : Phase + PH_W'(1);
        ovs_d   = 1'b1;
        bit_d   = (Phase == PH_LAST);
        mid_d   = (Phase == PH_MID);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      div_q   <= DIV_W'(RESET_DIV);
      frac_q  <= FRAC_W'(RESET_FRAC);
      acc     <= '0;
      carry_q <= 1'b0;
      cnt     <= CNT_ONE;
      Phase   <= '0;
      OvsTick <= 1'b0;
      BitTick <= 1'b0;
      MidTick <= 1'b0;
    end else begin
      div_q   <= div_d;
      frac_q  <= frac_d;
      acc     <= acc_d;
      carry_q <= carry_d;
      cnt     <= cnt_d;
      Phase   <= phase_d;
      OvsTick <= ovs_d;
      BitTick <= bit_d;
      MidTick <= mid_d;
    end
  end

endmodule

// File: doc/uart_baud_gen_frac.md
# uart_baud_gen_frac

Fractional-N UART baud/oversample tick generator, the parametrised successor to the integer baud-rate divider. It produces an oversample tick at Fclk / (Divisor + Frac/2^FRAC_W), plus a bit tick and a mid-bit tick derived from an oversample phase counter. It sits between the CSR block, which supplies the divisor, and the UART TX/RX engines: TX uses BitTick, RX uses OvsTick, MidTick and RxSync.

## Interface
- DIV_W, 16, width of the integer divisor.
- FRAC_W, 4, width of the fractional divisor; the fraction step is 1/2^FRAC_W.
- OVS, 16, oversample ticks per bit; must be even and ≥ 2.
- RESET_DIV, 27, integer divisor loaded at reset.
- RESET_FRAC, 0, fractional divisor loaded at reset.

Ports (direction, width, meaning):
- Clk  in  1  system clock; the only clock.
- Rst  in  1  asynchronous, active-high reset.
- En  in  1  count enable; when low, all state holds.
- Load  in  1  single-cycle strobe that latches Divisor/Frac and restarts the generator.
- Divisor  in  DIV_W  integer divisor; 0 is treated as 1.
- Frac  in  FRAC_W  fractional divisor.
- RxSync  in  1  restarts the period and phase (driven by RX on the start-bit falling edge).
- OvsTick  out  1  one-cycle oversample tick.
- BitTick  out  1  one-cycle tick, once per OVS oversample ticks.
- MidTick  out  1  one-cycle tick at mid-bit.
- Phase  out  clog2(OVS)  current oversample phase within the bit.

## Operation
- Internal registers:
  - div_q (DIV_W bits) and frac_q: active divisor.
  - cnt (DIV_W+1 bits): period counter.
  - acc (FRAC_W bits): fraction accumulator.
  - carry_q: one-bit extension of the current period.
  - Phase.
- Effective period: P = max(div_q,1) + carry_q, computed at DIV_W+1 bits so there is no overflow at div_q = all-ones with carry set.
- Per-cycle priority, highest first:
  1. **Load**: div_q←Divisor, frac_q←Frac, cnt←1, acc←0, carry_q←0, Phase←0. All ticks are 0 in the following cycle.
  2. **RxSync**: cnt←1, Phase←0. acc and carry_q are held. Ticks are 0.
  3. **En=0**: all state holds. Ticks are 0.
  4. **En=1, cnt≠P**: cnt←cnt+1. Ticks are 0.
  5. **En=1, cnt==P** (tick event):
     - cnt←1.
     - {carry_q,acc}←acc+frac_q, with the carry taken from bit FRAC_W.
     - Phase←(Phase==OVS-1) ? 0 : Phase+1.
     - OvsTick←1.
     - BitTick←1 if Phase was OVS-1.
     - MidTick←1 if Phase was OVS/2-1.
- All outputs are registered. Every tick is exactly one cycle wide and ticks never merge.
- The long-term average oversample period is div_q + frac_q/2^FRAC_W cycles. Each individual period is div_q or div_q+1 cycles.
- The carry produced at a tick extends the period that follows that tick, not the one that just ended.
- Divisor changes take effect only through Load. Changes on Divisor/Frac without Load are ignored.

## Timing
- Reset values:
  - OvsTick = 0, BitTick = 0, MidTick = 0, Phase = 0.
  - cnt = 1, acc = 0, carry_q = 0.
  - div_q = RESET_DIV, frac_q = RESET_FRAC.
- First tick: after Rst deasserts with En held high, the first OvsTick is visible after P enabled rising edges. After Load or RxSync, the first OvsTick is visible P enabled edges after the strobe edge.
- Edge cases:
  - **P=1**: OvsTick is high every enabled cycle.
  - **Simultaneous Load and RxSync**: Load wins.
  - **RxSync on a cnt==P cycle**: the tick is suppressed and the restart wins.
  - **En drop mid-period**: the remaining count resumes exactly where it stopped. No tick is lost or duplicated.
  - **Rst mid-operation**: all state returns to reset values immediately, asynchronously.
- Phase stays in the range 0..OVS-1 and never takes any other value.

## Test plan
- DIV=4, Frac=0, OVS=16, En=1 → OvsTick exactly every 4 cycles; BitTick every 64 cycles, coincident with the OvsTick at which Phase wraps 15→0; MidTick at Phase 7→8.
- Load Divisor=4, Frac=8 (FRAC_W=4) → OvsTick periods 4,4,5,4,5,4,5…; over 1600 ticks the total cycle count is 7199.
- Divisor=0 and Divisor=1 → OvsTick every cycle; BitTick every OVS cycles.
- Divisor=10, toggle En low for 3 cycles mid-period → the next OvsTick is delayed by exactly 3 cycles; the tick count is unchanged.
- Issue RxSync at Phase=5, cnt=7, Divisor=10 → no tick that cycle; Phase=0; next OvsTick 10 cycles later; MidTick after 8 OvsTicks.
- Assert Rst mid-period, plus Load and RxSync in the same cycle → reset values appear with no clock edge required; for Load+RxSync, div_q takes the new Divisor and acc=0.
